// File: rtl/jtcps_line_dma.sv
// jtcps_line_dma
// Parametrised per-line VRAM-to-cache DMA engine.
//
// At every line start it fetches a programmable run of words for each
// enabled channel from shared VRAM. The words go into a double-buffered
// cache for that channel. Tile engines read the bank that was filled during
// the previous line, while the engine fills the other bank.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cen                 transfer clock enable (gates address issue)
//   line_start          one-cycle pulse at the HB rising edge
//   ch_en               per-channel enable, sampled at line_start
//   ch_base             packed start word addresses, channel i at [i*AW +: AW]
//   ch_len              packed run lengths, channel i at [i*CW +: CW], 0 = skip
//   rd_ch/rd_addr       cache read request
//   rd_data             cache read data, one cycle after the request
//   br/bg               bus request / grant towards the VRAM arbiter
//   bus_addr/bus_cs     VRAM word address and read strobe
//   bus_data/bus_ok     VRAM read data and its valid flag
//   busy                some channel still has words to fetch this line
//   done                one-cycle pulse when the last pending channel finishes
//   overrun             one-cycle pulse per channel still unfinished at line_start

module jtcps_line_dma #(
  parameter int NCH = 3,
  parameter int CHW = 2,
  parameter int AW  = 17,
  parameter int DW  = 16,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              line_start,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*AW-1:0] ch_base,
  input  logic [NCH*CW-1:0] ch_len,
  input  logic [CHW-1:0]    rd_ch,
  input  logic [CW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              br,
  input  logic              bg,
  output logic [AW-1:0]     bus_addr,
  output logic              bus_cs,
  input  logic [DW-1:0]     bus_data,
  input  logic              bus_ok,
  output logic              busy,
  output logic              done,
  output logic [NCH-1:0]    overrun
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] ADDR = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] NEXT = 3'd4;

  // The cache index is {channel, bank, word}.
  localparam int CIDX = CHW + 1 + CW;

  logic [2:0]     state;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] swap;
  logic [NCH-1:0] active;
  logic [AW-1:0]  base_r [NCH];
  logic [CW-1:0]  len_r  [NCH];
  logic [CHW-1:0] ch;
  logic [CW-1:0]  cnt;
  logic           seen;

  logic [DW-1:0]  cache [2**CIDX];

  logic [NCH-1:0] new_pending;
  logic [NCH-1:0] sel_mask;
  logic [NCH-1:0] rem_pending;
  logic [AW-1:0]  cur_base;
  logic [CW-1:0]  cur_len;
  logic           cur_active;
  logic           rd_bank;
  logic           accept;
  logic           last;
  logic [CIDX-1:0] wr_idx;
  logic [CIDX-1:0] rd_idx;

  // Priority pick. The loop runs from the highest index down, so the lowest
  // set bit is the one written last and wins.
  function automatic logic [CHW-1:0] lowest(input logic [NCH-1:0] v);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) lowest = CHW'(i);
    end
  endfunction

  assign sel_mask    = NCH'(1) << ch;
  assign rem_pending = pending & ~sel_mask;
  assign busy        = |pending;

  // Channels that will run on the coming line. A zero-length channel is
  // skipped, even when it is enabled.
  always_comb begin
    new_pending = '0;
    for (int i = 0; i < NCH; i++) begin
      new_pending[i] = ch_en[i] && (ch_len[i*CW +: CW] != '0);
    end
  end

  // The current channel's latched settings and its bank bit, plus the bank
  // bit of the channel being read. Both are picked with explicit compares,
  // so an unused channel index never reaches past the arrays.
  always_comb begin
    cur_base   = '0;
    cur_len    = '0;
    cur_active = 1'b0;
    rd_bank    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == CHW'(i)) begin
        cur_base   = base_r[i];
        cur_len    = len_r[i];
        cur_active = active[i];
      end
      if (rd_ch == CHW'(i)) rd_bank = active[i];
    end
  end

  // A word is taken only from the second WAIT cycle onward. By then bus_ok
  // refers to the address issued by this engine, not to a leftover one.
  assign accept = (state == WAIT) && bg && seen && bus_ok;
  assign last   = (cnt == cur_len - 1'b1);
  assign wr_idx = {ch, ~cur_active, cnt};
  assign rd_idx = {rd_ch, rd_bank, rd_addr};

  // Cache storage. Writes go to the inactive bank and reads come from the
  // active bank, so a reader and the DMA never touch the same word.
  always_ff @(posedge clk) begin
    if (accept) cache[wr_idx] <= bus_data;
    rd_data <= cache[rd_idx];
  end

  // Control FSM. line_start overrides whatever the FSM was doing. A fetch
  // that is still in flight is dropped, and the channel restarts from word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      swap     <= '0;
      active   <= '0;
      ch       <= '0;
      cnt      <= '0;
      seen     <= 1'b0;
      br       <= 1'b0;
      bus_cs   <= 1'b0;
      bus_addr <= '0;
      done     <= 1'b0;
      overrun  <= '0;
      for (int i = 0; i < NCH; i++) begin
        base_r[i] <= '0;
        len_r[i]  <= '0;
      end
    end else begin
      done    <= 1'b0;
      overrun <= '0;
      if (line_start) begin
        // Only channels that finished have a swap bit set. An overrun channel
        // therefore keeps showing its previous complete line.
        active  <= active ^ swap;
        swap    <= '0;
        overrun <= pending;
        pending <= new_pending;
        for (int i = 0; i < NCH; i++) begin
          base_r[i] <= ch_base[i*AW +: AW];
          len_r[i]  <= ch_len[i*CW +: CW];
        end
        ch     <= lowest(new_pending);
        cnt    <= '0;
        seen   <= 1'b0;
        bus_cs <= 1'b0;
        if (|new_pending) begin
          state <= REQ;
          br    <= 1'b1;
        end else begin
          state <= IDLE;
          br    <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: br <= 1'b0;
          REQ: begin
            br <= 1'b1;
            if (bg) state <= ADDR;
          end
          ADDR: begin
            if (!bg) begin
              bus_cs <= 1'b0;
            end else if (cen) begin
              bus_addr <= cur_base + AW'(cnt);
              bus_cs   <= 1'b1;
              seen     <= 1'b0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            // Losing the grant drops the strobe and keeps cnt. The same word
            // is then fetched again once bg returns.
            if (!bg) begin
              bus_cs <= 1'b0;
              state  <= ADDR;
            end else begin
              seen <= 1'b1;
              if (seen && bus_ok) begin
                cnt    <= cnt + 1'b1;
                bus_cs <= 1'b0;
                state  <= last ? NEXT : ADDR;
              end
            end
          end
          NEXT: begin
            pending <= rem_pending;
            swap    <= swap | sel_mask;
            cnt     <= '0;
            if (|rem_pending) begin
              ch    <= lowest(rem_pending);
              state <= ADDR;
            end else begin
              done  <= 1'b1;
              br    <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtcps_line_dma.sv
// tb_jtcps_line_dma
// Directed self-checking bench for jtcps_line_dma (NCH=3, AW=17, CW=8).
// A behavioural VRAM model answers each strobe. In the normal mode it
// answers three cycles after the strobe; in the other mode bus_ok is held
// high all the time. Its data is a fixed function of the address, so the
// expected cache contents can be worked out by hand.

module tb_jtcps_line_dma;

  localparam int NCH = 3;
  localparam int CHW = 2;
  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cen;
  logic              line_start;
  logic [NCH-1:0]    ch_en;
  logic [NCH*AW-1:0] ch_base;
  logic [NCH*CW-1:0] ch_len;
  logic [CHW-1:0]    rd_ch;
  logic [CW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              br;
  logic              bg;
  logic [AW-1:0]     bus_addr;
  logic              bus_cs;
  logic [DW-1:0]     bus_data = '0;
  logic              bus_ok = 1'b0;
  logic              busy;
  logic              done;
  logic [NCH-1:0]    overrun;

  int checks = 0;
  int failures = 0;

  logic          ok_held = 1'b0;
  int            cs_age = 0;
  logic          prev_cs = 1'b0;
  logic [AW-1:0] issued [$];
  int            done_cnt = 0;

  jtcps_line_dma #(.NCH(NCH), .CHW(CHW), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .line_start(line_start),
    .ch_en(ch_en), .ch_base(ch_base), .ch_len(ch_len),
    .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .br(br), .bg(bg), .bus_addr(bus_addr), .bus_cs(bus_cs),
    .bus_data(bus_data), .bus_ok(bus_ok),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // VRAM data pattern: a fixed function of the word address.
  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return {a[16] ^ a[15], a[14:0]} ^ 16'h5A3C;
  endfunction

  function automatic logic [NCH*AW-1:0] pack_base(input logic [AW-1:0] b0, b1, b2);
    return {b2, b1, b0};
  endfunction

  function automatic logic [NCH*CW-1:0] pack_len(input logic [CW-1:0] l0, l1, l2);
    return {l2, l1, l0};
  endfunction

  // VRAM model and bus monitor, evaluated on the falling edge.
  // Every rising edge of bus_cs is logged as one issued address.
  always @(negedge clk) begin
    if (bus_cs) cs_age = cs_age + 1;
    else cs_age = 0;
    bus_ok   = ok_held ? 1'b1 : (cs_age >= 3);
    bus_data = fdat(bus_addr);
    if (bus_cs && !prev_cs) issued.push_back(bus_addr);
    prev_cs = bus_cs;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_line(input logic [NCH-1:0] en, input logic [NCH*AW-1:0] b,
                            input logic [NCH*CW-1:0] l);
    @(negedge clk);
    ch_en = en; ch_base = b; ch_len = l; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output logic got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
  endtask

  task automatic wait_issue(input logic [AW-1:0] a, input int maxc, output logic got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (bus_cs && bus_addr == a) got = 1'b1;
    end
  endtask

  task automatic read_word(input int c, input int a, output logic [DW-1:0] d);
    @(negedge clk);
    rd_ch = CHW'(c); rd_addr = CW'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset;
    rst = 1'b1; cen = 1'b1; line_start = 1'b0; bg = 1'b1;
    ch_en = '0; ch_base = '0; ch_len = '0; rd_ch = '0; rd_addr = '0;
    tick(3);
    checks++; if (br !== 1'b0) begin failures++; $display("[TB] FAIL reset_br: got %b want 0", br); end
    checks++; if (bus_cs !== 1'b0) begin failures++; $display("[TB] FAIL reset_cs: got %b want 0", bus_cs); end
    checks++; if (bus_addr !== '0) begin failures++; $display("[TB] FAIL reset_addr: got %h want 0", bus_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (overrun !== '0) begin failures++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
    @(negedge clk);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_main;
    logic got;
    logic [AW-1:0] exp [$];
    logic [AW-1:0] v;
    logic [DW-1:0] d;
    issued.delete(); done_cnt = 0;
    for (int i = 0; i < 4; i++) exp.push_back(AW'(17'h100 + i));
    for (int i = 0; i < 8; i++) exp.push_back(AW'(17'h2000 + i));
    exp.push_back(17'h1FFFF);
    exp.push_back(17'h00000);
    pulse_line(3'b111, pack_base(17'h100, 17'h2000, 17'h1FFFF), pack_len(8'd4, 8'd8, 8'd2));
    wait_done(600, got);
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL main_done_timeout: got %b want 1", got); end
    tick(5);
    checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL main_done_count: got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL main_busy_end: got %b want 0", busy); end
    checks++; if (br !== 1'b0) begin failures++; $display("[TB] FAIL main_br_end: got %b want 0", br); end
    checks++; if (issued.size() != exp.size()) begin failures++; $display("[TB] FAIL main_issue_count: got %0d want %0d", issued.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      v = (i < issued.size()) ? issued[i] : 'x;
      checks++; if (v !== exp[i]) begin failures++; $display("[TB] FAIL main_addr[%0d]: got %h want %h", i, v, exp[i]); end
    end
    // Bring the freshly filled banks into view and read them back.
    pulse_line(3'b000, pack_base(17'h100, 17'h2000, 17'h1FFFF), pack_len(8'd4, 8'd8, 8'd2));
    for (int i = 0; i < 4; i++) begin
      read_word(0, i, d);
      checks++; if (d !== fdat(AW'(17'h100 + i))) begin failures++; $display("[TB] FAIL main_rd_ch0[%0d]: got %h want %h", i, d, fdat(AW'(17'h100 + i))); end
    end
    for (int i = 0; i < 8; i++) begin
      read_word(1, i, d);
      checks++; if (d !== fdat(AW'(17'h2000 + i))) begin failures++; $display("[TB] FAIL main_rd_ch1[%0d]: got %h want %h", i, d, fdat(AW'(17'h2000 + i))); end
    end
    read_word(2, 0, d);
    checks++; if (d !== fdat(17'h1FFFF)) begin failures++; $display("[TB] FAIL main_rd_ch2[0]: got %h want %h", d, fdat(17'h1FFFF)); end
    read_word(2, 1, d);
    checks++; if (d !== fdat(17'h00000)) begin failures++; $display("[TB] FAIL main_rd_ch2[1]: got %h want %h", d, fdat(17'h00000)); end
  endtask

  task automatic test_partial_enable;
    logic got;
    logic [AW-1:0] v;
    logic [DW-1:0] d;
    issued.delete();
    pulse_line(3'b010, pack_base(17'h300, 17'h4000, 17'h500), pack_len(8'd4, 8'd8, 8'd2));
    wait_done(600, got);
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL part_done_timeout: got %b want 1", got); end
    tick(3);
    checks++; if (issued.size() != 8) begin failures++; $display("[TB] FAIL part_issue_count: got %0d want 8", issued.size()); end
    v = (issued.size() > 0) ? issued[0] : 'x;
    checks++; if (v !== 17'h4000) begin failures++; $display("[TB] FAIL part_first_addr: got %h want 04000", v); end
    pulse_line(3'b000, '0, '0);
    for (int i = 0; i < 8; i++) begin
      read_word(1, i, d);
      checks++; if (d !== fdat(AW'(17'h4000 + i))) begin failures++; $display("[TB] FAIL part_rd_ch1[%0d]: got %h want %h", i, d, fdat(AW'(17'h4000 + i))); end
    end
    // Disabled channels keep the previous line's data.
    for (int i = 0; i < 4; i++) begin
      read_word(0, i, d);
      checks++; if (d !== fdat(AW'(17'h100 + i))) begin failures++; $display("[TB] FAIL part_rd_ch0[%0d]: got %h want %h", i, d, fdat(AW'(17'h100 + i))); end
    end
    read_word(2, 0, d);
    checks++; if (d !== fdat(17'h1FFFF)) begin failures++; $display("[TB] FAIL part_rd_ch2[0]: got %h want %h", d, fdat(17'h1FFFF)); end
  endtask

  task automatic test_overrun;
    logic got;
    logic [AW-1:0] v;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    issued.delete();
    pulse_line(3'b010, pack_base(17'h0, 17'h6000, 17'h0), pack_len(8'd4, 8'd8, 8'd2));
    wait_issue(17'h6005, 300, got);
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL ovr_word5_timeout: got %b want 1", got); end
    // A new line starts while word 5 is still outstanding.
    ch_en = 3'b010; ch_base = pack_base(17'h0, 17'h7000, 17'h0); ch_len = pack_len(8'd4, 8'd4, 8'd2);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    checks++; if (overrun !== 3'b010) begin failures++; $display("[TB] FAIL ovr_pulse: got %b want 010", overrun); end
    checks++; if (bus_cs !== 1'b0) begin failures++; $display("[TB] FAIL ovr_cs_abandon: got %b want 0", bus_cs); end
    @(negedge clk);
    checks++; if (overrun !== 3'b000) begin failures++; $display("[TB] FAIL ovr_pulse_len: got %b want 000", overrun); end
    // Channel 1 was not swapped, so it still shows the line fetched at 0x4000.
    read_word(1, 2, d);
    checks++; if (d !== fdat(17'h4002)) begin failures++; $display("[TB] FAIL ovr_no_swap: got %h want %h", d, fdat(17'h4002)); end
    wait_done(600, got);
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL ovr_done_timeout: got %b want 1", got); end
    tick(3);
    checks++; if (issued.size() != 10) begin failures++; $display("[TB] FAIL ovr_issue_count: got %0d want 10", issued.size()); end
    v = (issued.size() > 6) ? issued[6] : 'x;
    checks++; if (v !== 17'h7000) begin failures++; $display("[TB] FAIL ovr_restart_addr: got %h want 07000", v); end
    pulse_line(3'b000, '0, '0);
    // Bank contents: words 0-3 come from the new run and word 4 from the
    // aborted run. Words 5-7 still hold the older line because word 5 of the
    // aborted run was never written.
    for (int i = 0; i < 8; i++) begin
      read_word(1, i, d);
      if (i < 4) exp = fdat(AW'(17'h7000 + i));
      else if (i == 4) exp = fdat(17'h6004);
      else exp = fdat(AW'(17'h2000 + i));
      checks++; if (d !== exp) begin failures++; $display("[TB] FAIL ovr_rd_ch1[%0d]: got %h want %h", i, d, exp); end
    end
  endtask

  task automatic test_bg_pause;
    logic got;
    logic [AW-1:0] v;
    logic [AW-1:0] exp [7];
    logic [DW-1:0] d;
    int gap_cs;
    int gap_br;
    exp = '{17'h800, 17'h801, 17'h802, 17'h803, 17'h803, 17'h804, 17'h805};
    issued.delete();
    pulse_line(3'b001, pack_base(17'h800, 17'h0, 17'h0), pack_len(8'd6, 8'd8, 8'd2));
    wait_issue(17'h803, 300, got);
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL bg_word3_timeout: got %b want 1", got); end
    bg = 1'b0;
    gap_cs = 0; gap_br = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_cs) gap_cs++;
      if (!br) gap_br++;
    end
    bg = 1'b1;
    checks++; if (gap_cs != 0) begin failures++; $display("[TB] FAIL bg_cs_in_gap: got %0d cycles want 0", gap_cs); end
    checks++; if (gap_br != 0) begin failures++; $display("[TB] FAIL bg_br_in_gap: got %0d low cycles want 0", gap_br); end
    wait_done(600, got);
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL bg_done_timeout: got %b want 1", got); end
    tick(3);
    checks++; if (issued.size() != 7) begin failures++; $display("[TB] FAIL bg_issue_count: got %0d want 7", issued.size()); end
    for (int i = 0; i < 7; i++) begin
      v = (i < issued.size()) ? issued[i] : 'x;
      checks++; if (v !== exp[i]) begin failures++; $display("[TB] FAIL bg_addr[%0d]: got %h want %h", i, v, exp[i]); end
    end
    pulse_line(3'b000, '0, '0);
    for (int i = 0; i < 6; i++) begin
      read_word(0, i, d);
      checks++; if (d !== fdat(AW'(17'h800 + i))) begin failures++; $display("[TB] FAIL bg_rd_ch0[%0d]: got %h want %h", i, d, fdat(AW'(17'h800 + i))); end
    end
  endtask

  task automatic test_ok_held;
    logic got;
    logic [DW-1:0] d;
    int runs [$];
    int run;
    ok_held = 1'b1;
    run = 0; got = 1'b0;
    pulse_line(3'b100, pack_base(17'h0, 17'h0, 17'hA00), pack_len(8'd4, 8'd8, 8'd5));
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (bus_cs) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (done) got = 1'b1;
    end
    ok_held = 1'b0;
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL held_done_timeout: got %b want 1", got); end
    checks++; if (runs.size() != 5) begin failures++; $display("[TB] FAIL held_word_count: got %0d want 5", runs.size()); end
    // A word accepted on the second WAIT cycle keeps the strobe high for two cycles.
    foreach (runs[i]) begin
      checks++; if (runs[i] != 2) begin failures++; $display("[TB] FAIL held_cs_len[%0d]: got %0d want 2", i, runs[i]); end
    end
    pulse_line(3'b000, '0, '0);
    for (int i = 0; i < 5; i++) begin
      read_word(2, i, d);
      checks++; if (d !== fdat(AW'(17'hA00 + i))) begin failures++; $display("[TB] FAIL held_rd_ch2[%0d]: got %h want %h", i, d, fdat(AW'(17'hA00 + i))); end
    end
  endtask

  task automatic test_reset_mid;
    logic got;
    logic [AW-1:0] v;
    logic [DW-1:0] d;
    pulse_line(3'b111, pack_base(17'h100, 17'h2000, 17'h1FFFF), pack_len(8'd4, 8'd8, 8'd2));
    wait_issue(17'h2002, 300, got);
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL rmid_issue_timeout: got %b want 1", got); end
    rst = 1'b1;
    #1;
    checks++; if (br !== 1'b0) begin failures++; $display("[TB] FAIL rmid_br: got %b want 0", br); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (bus_cs !== 1'b0) begin failures++; $display("[TB] FAIL rmid_cs: got %b want 0", bus_cs); end
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    checks++; if (br !== 1'b0) begin failures++; $display("[TB] FAIL rmid_br_after: got %b want 0", br); end
    issued.delete();
    pulse_line(3'b111, pack_base(17'hB00, 17'hC00, 17'hD00), pack_len(8'd2, 8'd2, 8'd2));
    wait_done(600, got);
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL rmid_done_timeout: got %b want 1", got); end
    tick(3);
    checks++; if (issued.size() != 6) begin failures++; $display("[TB] FAIL rmid_issue_count: got %0d want 6", issued.size()); end
    v = (issued.size() > 0) ? issued[0] : 'x;
    checks++; if (v !== 17'hB00) begin failures++; $display("[TB] FAIL rmid_first_addr: got %h want 00b00", v); end
    pulse_line(3'b000, '0, '0);
    read_word(0, 0, d);
    checks++; if (d !== fdat(17'hB00)) begin failures++; $display("[TB] FAIL rmid_rd_ch0: got %h want %h", d, fdat(17'hB00)); end
    read_word(2, 1, d);
    checks++; if (d !== fdat(17'hD01)) begin failures++; $display("[TB] FAIL rmid_rd_ch2: got %h want %h", d, fdat(17'hD01)); end
  endtask

  // Scenario sequence
  initial begin
    test_reset;
    test_main;
    test_partial_enable;
    test_overrun;
    test_bg_pause;
    test_ok_held;
    test_reset_mid;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Last-resort guard so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got timeout want completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule

// File: doc/jtcps_line_dma.md
Name: jtcps_line_dma

Overview:
- Parametrised per-line VRAM-to-cache DMA engine. Successor to the fixed three-scroll line DMA; channel count, cache depth and address width are configurable.
- At every line start it fetches a programmable run of words per enabled channel from shared VRAM into a per-channel double-buffered cache. Tile engines read the previous line's bank through a 1-cycle read port.
- Sits between the CPS video register block and the SDRAM/VRAM arbiter. It adds line-overrun detection and bus-grant pause/resume, which the earlier block lacked.

Parameters:
NCH, 3, number of channels (1..4)
CHW, 2, channel index width, must satisfy 2^CHW >= NCH
AW, 17, VRAM word-address width
DW, 16, data width
CW, 8, cache address width per bank (2^CW words per channel bank)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cen  in  1  transfer clock enable; a new address is issued only on cen
line_start  in  1  one-cycle pulse at HB rising edge
ch_en  in  NCH  channel enable, sampled at line_start
ch_base  in  NCH*AW  start word address per channel; channel i at [i*AW +: AW]
ch_len  in  NCH*CW  words per line, channel i at [i*CW +: CW]; 0 = skip channel
rd_ch  in  CHW  cache read channel
rd_addr  in  CW  cache read address
rd_data  out  DW  cache read data, 1-cycle latency
br  out  1  bus request
bg  in  1  bus grant
bus_addr  out  AW  VRAM word address
bus_cs  out  1  VRAM read strobe
bus_data  in  DW  VRAM data
bus_ok  in  1  bus_data valid for current bus_addr
busy  out  1  any channel pending
done  out  1  one-cycle pulse when all pending channels have finished
overrun  out  NCH  one-cycle pulse per channel left unfinished at line_start

Behaviour:
- Reset: br=0, bus_cs=0, bus_addr=0, busy=0, done=0, overrun=0. All pending, swap and active-bank bits clear; FSM returns to IDLE. Cache contents are undefined after reset. rst asserted mid-transfer aborts at once and writes nothing further.
- Banks: each channel has an active bit. Reads use bank active[rd_ch] and writes use ~active[ch]. Cache index = {ch, bank, addr}.
- line_start, in the same cycle:
  - active ^= swap; swap cleared.
  - Any channel still pending raises its overrun bit for 1 cycle and is not swapped. An in-flight fetch is abandoned: bus_cs=0, no cache write.
  - pending = ch_en & (ch_len!=0); base/len are latched per channel.
  - FSM goes to REQ if pending!=0, else IDLE.
- FSM states IDLE, REQ, ADDR, WAIT, NEXT.
  - IDLE: br=0.
  - REQ: br=1; waits for bg.
  - ADDR: on cen, bus_addr = base+cnt with modulo-2^AW wrap; bus_cs=1; go to WAIT.
  - WAIT: bus_cs held. A word is accepted when bus_ok=1, no earlier than the 2nd WAIT cycle, so a stale ok is ignored. On acceptance: write cache[cnt], cnt++. If cnt was len-1, go to NEXT, otherwise go to ADDR.
  - NEXT: clear the pending bit, set the swap bit, cnt=0; next channel is the lowest pending index. If pending remains, go to ADDR with br held; otherwise done pulse, br=0, IDLE.
- Channel order is fixed priority, lowest index first; the current channel is never preempted.
- bg deasserted while in ADDR/WAIT: bus_cs=0, state and cnt held, re-enter ADDR when bg returns. The word is refetched; no duplicate write.
- busy = |pending. done and overrun never assert in the same cycle for the same channel.
- Cache write and a read of the same channel never collide, because they target different banks.
- ch_len = 2^CW-1 is the maximum run. A wrap past the last address is allowed.

Test Plan:
- NCH=3, len={4,8,2}, base={0x100,0x2000,0x1FFFF}, bus_ok 3 cycles after cs, bg tied 1 -> bus_addr sequence 0x100..0x103, 0x2000..0x2007, 0x1FFFF then 0x00000; done pulses once. After the next line_start, each channel's read bank returns the fetched data.
- ch_en=3'b010 -> only channel 1 fetched; channels 0 and 2 do not swap, and their read data stays as it was on the prior line.
- line_start while channel 1 is at word 5 of 8 -> overrun=3'b010 for 1 cycle. Channel 1 is not swapped and restarts at word 0; no write for word 5.
- bg dropped for 10 cycles during WAIT of word 3 -> bus_cs=0 during the gap; word 3 refetched; cache holds exactly len words in order.
- bus_ok held high continuously -> each word is accepted no earlier than the 2nd WAIT cycle after its address; no word is skipped.
- rst pulsed mid-transfer -> br=0 and busy=0 immediately; the next line_start starts cleanly from channel 0.
